// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared UART data width, arbiter state encoding and counter sizing
package uart_tx_arbiter_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_SEND = 2'd1;
  localparam arb_state_t ST_GAP  = 2'd2;

  // One spare bit so a counter can hold its own limit without wrapping.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// rtl/uart_rr_arb2.sv - two-way round-robin select; rr points at the requester favoured on a tie
module uart_rr_arb2 (
  input  logic sysclk,
  input  logic rst,
  input  logic enable,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant0,
  output logic grant1
);

  logic rr;

  always_comb begin
    grant1 = enable & req1_valid & (~req0_valid | rr);
    grant0 = enable & req0_valid & (~req1_valid | ~rr);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (grant0) begin
      rr <= 1'b1;
    end else if (grant1) begin
      rr <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between two byte requesters
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req0_byte,
  input  logic [DATA_WIDTH-1:0] req1_byte,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_byte,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_grant,
  output logic                  o_timeout
);

  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state;
  arb_state_t    next_state;
  logic [TW-1:0] send_cnt;
  logic [GW-1:0] gap_cnt;
  logic          arb_en;
  logic          grant0;
  logic          grant1;
  logic          fire;
  logic          timeout_hit;

  // Holding arb_en low during reset keeps a same-cycle request from being accepted.
  assign arb_en      = (state == ST_IDLE) & ~rst;
  assign fire        = grant0 | grant1;
  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign timeout_hit = (state == ST_SEND) && (send_cnt == TO_LAST);

  uart_rr_arb2 u_arb (
    .sysclk     (sysclk),
    .rst        (rst),
    .enable     (arb_en),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (fire) next_state = ST_SEND;
      ST_SEND: if (i_tx_done || timeout_hit) next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt == GAP_LAST) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start = (state == ST_SEND);
    o_busy     = (state != ST_IDLE);
    o_timeout  = timeout_hit & ~i_tx_done;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      o_tx_byte <= '0;
      o_grant   <= 1'b0;
      send_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      if (fire) begin
        o_tx_byte <= grant1 ? req1_byte : req0_byte;
        o_grant   <= grant1;
      end
      if (state == ST_SEND && next_state == ST_SEND && send_cnt != TO_LAST) begin
        send_cnt <= send_cnt + 1'b1;
      end else begin
        send_cnt <= '0;
      end
      if (state == ST_GAP && next_state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a byte/grant scoreboard
module tb_uart_tx_arbiter;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic [7:0] req0_byte = '0;
  logic [7:0] req1_byte = '0;
  logic       i_tx_done = 1'b0;

  logic       req0_ready, req1_ready, o_tx_start, o_busy, o_grant, o_timeout;
  logic [7:0] o_tx_byte;
  logic       b_req0_ready, b_req1_ready, b_tx_start, b_busy, b_grant, b_timeout;
  logic [7:0] b_tx_byte;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       grant;
  } exp_t;
  exp_t sbq[$];
  bit   model_rr = 1'b0;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(.GAP_CYCLES(16), .TIMEOUT_CYCLES(50)) u_dut (
    .sysclk(sysclk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_byte(req0_byte), .req1_byte(req1_byte),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  uart_tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(50)) u_dut_nogap (
    .sysclk(sysclk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_byte(req0_byte), .req1_byte(req1_byte),
    .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
    .o_tx_start(b_tx_start), .o_tx_byte(b_tx_byte), .i_tx_done(i_tx_done),
    .o_busy(b_busy), .o_grant(b_grant), .o_timeout(b_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of the round-robin choice; pushes the expected byte/grant.
  task automatic predict(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    exp_t e;
    if (v1 && (!v0 || model_rr)) begin
      e.data = d1; e.grant = 1'b1; model_rr = 1'b0;
    end else begin
      e.data = d0; e.grant = 1'b0; model_rr = 1'b1;
    end
    sbq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge sysclk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; i_tx_done = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b0; model_rr = 1'b0;
  endtask

  // Entered at posedge+1 of the first SEND cycle; returns at negedge of the first cycle after SEND.
  task automatic run_send(input int done_on, output int n_send, output int n_to, output int to_at);
    exp_t e;
    n_send = 0; n_to = 0; to_at = 0;
    for (int k = 1; k <= 300; k++) begin
      i_tx_done = (k == done_on);
      @(negedge sysclk);
      if (!o_tx_start) break;
      n_send++;
      if (o_timeout) begin n_to++; to_at = k; end
      chk("ready_in_send", 32'({req0_ready, req1_ready}), 32'd0);
      if (k == 1) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("tx_byte", 32'(o_tx_byte), 32'(e.data));
          chk("grant", 32'(o_grant), 32'(e.grant));
        end
      end
      next_cycle();
    end
    i_tx_done = 1'b0;
  endtask

  // Counts busy cycles after SEND; ends at negedge of the first IDLE cycle.
  task automatic count_gap(output int n_gap);
    n_gap = 0;
    for (int k = 0; k < 100; k++) begin
      if (!o_busy) break;
      n_gap++;
      next_cycle();
      @(negedge sysclk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_send, n_to, to_at, n_gap;

    // Reset state
    next_cycle(); next_cycle();
    @(negedge sysclk);
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    chk("rst_tx_byte", 32'(o_tx_byte), 32'd0);

    // Single byte from requester 0, same-cycle ready
    next_cycle();
    rst = 1'b0; req0_valid = 1'b1; req0_byte = 8'hA5;
    predict(1'b1, 8'hA5, 1'b0, 8'h00);
    @(negedge sysclk);
    chk("a5_ready0", 32'(req0_ready), 32'd1);
    chk("a5_ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    req0_valid = 1'b0;
    run_send(3, n_send, n_to, to_at);
    chk("a5_send_cycles", 32'(n_send), 32'd3);
    chk("a5_no_timeout", 32'(n_to), 32'd0);
    count_gap(n_gap);
    chk("a5_gap", 32'(n_gap), 32'd16);

    // Back-to-back alternation
    do_reset();
    req0_valid = 1'b1; req0_byte = 8'h11; req1_valid = 1'b1; req1_byte = 8'h22;
    for (int i = 0; i < 4; i++) predict(1'b1, 8'h11, 1'b1, 8'h22);
    @(negedge sysclk);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", 32'({req1_ready, req0_ready}), (i % 2 == 0) ? 32'd1 : 32'd2);
      next_cycle();
      run_send(2, n_send, n_to, to_at);
      chk("b2b_send_cycles", 32'(n_send), 32'd2);
      count_gap(n_gap);
      chk("b2b_gap", 32'(n_gap), 32'd16);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    @(negedge sysclk);
    chk("b2b_idle", 32'(o_busy), 32'd0);

    // Timeout with done held low
    next_cycle();
    req1_valid = 1'b1; req1_byte = 8'h5A;
    predict(1'b0, 8'h00, 1'b1, 8'h5A);
    @(negedge sysclk);
    chk("to_ready1", 32'(req1_ready), 32'd1);
    next_cycle();
    req1_valid = 1'b0;
    run_send(0, n_send, n_to, to_at);
    chk("to_send_cycles", 32'(n_send), 32'd50);
    chk("to_pulses", 32'(n_to), 32'd1);
    chk("to_pulse_cycle", 32'(to_at), 32'd50);
    count_gap(n_gap);
    chk("to_gap", 32'(n_gap), 32'd16);

    // Done on the timeout cycle wins
    next_cycle();
    req0_valid = 1'b1; req0_byte = 8'h66;
    predict(1'b1, 8'h66, 1'b0, 8'h00);
    next_cycle();
    req0_valid = 1'b0;
    run_send(50, n_send, n_to, to_at);
    chk("tie_send_cycles", 32'(n_send), 32'd50);
    chk("tie_pulses", 32'(n_to), 32'd0);
    count_gap(n_gap);
    chk("tie_gap", 32'(n_gap), 32'd16);

    // Reset three cycles into SEND, then requester 1
    next_cycle();
    req0_valid = 1'b1; req0_byte = 8'h77;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle(); next_cycle();
    @(negedge sysclk);
    chk("mid_send_active", 32'(o_tx_start), 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; model_rr = 1'b0;
    req1_valid = 1'b1; req1_byte = 8'h3C;
    predict(1'b0, 8'h00, 1'b1, 8'h3C);
    @(negedge sysclk);
    chk("mid_rst_start", 32'(o_tx_start), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_byte", 32'(o_tx_byte), 32'd0);
    chk("mid_rst_ready1", 32'(req1_ready), 32'd1);
    next_cycle();
    req1_valid = 1'b0;
    run_send(1, n_send, n_to, to_at);
    chk("3c_send_cycles", 32'(n_send), 32'd1);
    count_gap(n_gap);
    chk("3c_gap", 32'(n_gap), 32'd16);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    // GAP_CYCLES=0 instance: done -> IDLE next cycle -> ready that cycle
    do_reset();
    req0_valid = 1'b1; req0_byte = 8'h81;
    @(negedge sysclk);
    chk("ng_ready0", 32'(b_req0_ready), 32'd1);
    next_cycle();
    i_tx_done = 1'b1;
    @(negedge sysclk);
    chk("ng_start", 32'(b_tx_start), 32'd1);
    chk("ng_byte", 32'(b_tx_byte), 32'h81);
    next_cycle();
    i_tx_done = 1'b0;
    @(negedge sysclk);
    chk("ng_idle_busy", 32'(b_busy), 32'd0);
    chk("ng_idle_start", 32'(b_tx_start), 32'd0);
    chk("ng_ready_again", 32'(b_req0_ready), 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge sysclk);
    chk("ng_restart", 32'(b_tx_start), 32'd1);
    chk("ng_no_timeout", 32'(b_timeout), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 16: idle cycles enforced between consecutive bytes (0 allowed).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 200000: maximum cycles to wait for tx done (must be >= 1).
REQ-003 The block SHALL have port sysclk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1 each  requester holds a byte pending.
REQ-006 The block SHALL have ports req0_byte / req1_byte  input  DATA_WIDTH each  byte to send, held stable while its valid is high.
REQ-007 The block SHALL have ports req0_ready / req1_ready  output  1 each  accept strobe; a byte transfers on any cycle where valid and ready are both high.
REQ-008 The block SHALL have port o_tx_start  output  1  drives the transmitter's i_tx enable.
REQ-009 The block SHALL have port o_tx_byte  output  DATA_WIDTH  drives the transmitter's i_tx_byte.
REQ-010 The block SHALL have port i_tx_done  input  1  transmitter's o_tx_d completion pulse.
REQ-011 The block SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port o_grant  output  1  index of the requester owning the current or last transfer.
REQ-013 The block SHALL have port o_timeout  output  1  one-cycle pulse on transmitter timeout.

Function
REQ-014 The FSM SHALL have states IDLE, SEND and GAP.
REQ-015 In IDLE, ready SHALL be combinational and asserted for at most one requester: the only valid requester, or the one selected by the round-robin pointer rr when both are valid.
REQ-016 On transfer, the block SHALL latch the byte into o_tx_byte, set o_grant to the requester index, set rr to the other index, and enter SEND on the next cycle.
REQ-017 In SEND, o_tx_start SHALL be high and o_tx_byte SHALL be stable; no ready SHALL be asserted.
REQ-018 In SEND, i_tx_done=1 SHALL cause o_tx_start to drop on the next cycle and the FSM to enter GAP, or IDLE if GAP_CYCLES=0.
REQ-019 The SEND counter SHALL count cycles spent in SEND; if it reaches TIMEOUT_CYCLES-1 without i_tx_done, the block SHALL pulse o_timeout for one cycle and leave SEND as in REQ-018.
REQ-020 If i_tx_done and the timeout condition coincide, done SHALL win and o_timeout SHALL NOT pulse.
REQ-021 In GAP, the block SHALL count GAP_CYCLES cycles and then return to IDLE; i_tx_done SHALL be ignored in IDLE and GAP.
REQ-022 Latency: valid high in IDLE on cycle N SHALL give ready on cycle N and o_tx_start high on cycle N+1.
REQ-023 The block SHALL support back-to-back operation: with both requesters continuously valid, grants SHALL alternate 0,1,0,1.
REQ-024 A valid deasserted before ready SHALL be dropped without effect; no byte is queued internally beyond the single latched byte.
REQ-025 Counters SHALL be sized with $clog2 of their parameter plus 1 and SHALL never wrap: they saturate or clear on state exit.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL enter state IDLE with rr=0, o_tx_start=0, o_tx_byte=0, o_grant=0, o_timeout=0, o_busy=0 and both counters cleared.
REQ-027 Reset asserted mid-SEND SHALL drop o_tx_start on the next cycle and discard the latched byte.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 DATA_WIDTH SHALL come from the shared uart_params.vh; the state encoding SHALL be localparams in that header.
REQ-030 Arbitration SHALL be implemented in a sub-module uart_rr_arb2 (2-way round-robin select, rr pointer inside), instantiated once.
REQ-031 The block SHALL be instantiated between uart_top requesters and uart_tx; it contains no baud logic.

Verification
REQ-032 After reset, req0_valid=1 with byte 0xA5 SHALL produce req0_ready on the same cycle, o_tx_start=1 with o_tx_byte=0xA5 the next cycle, and o_grant=0.
REQ-033 With both requesters valid continuously (0x11 and 0x22), transmitted bytes SHALL be 0x11,0x22,0x11,0x22 and each SEND→IDLE SHALL include exactly 16 GAP cycles.
REQ-034 With TIMEOUT_CYCLES=50 and i_tx_done held low, o_timeout SHALL pulse on the 50th SEND cycle and the FSM SHALL then take GAP→IDLE.
REQ-035 With i_tx_done driven on exactly the timeout cycle, there SHALL be no o_timeout pulse and normal completion.
REQ-036 rst asserted 3 cycles into SEND SHALL give o_tx_start=0 and o_busy=0 on the next cycle; a following req1 byte 0x3C SHALL be granted with o_grant=1 (rr=0, req0 idle).
REQ-037 With GAP_CYCLES=0, i_tx_done SHALL lead to IDLE the next cycle and the next ready on the following cycle.
